// File: rtl/fifo_multi_ch.sv
// fifo_multi_ch: NUM_CH independent FIFOs sharing one push port and one pop port.
// Each channel has its own pointers, occupancy count and status flags. Pop data
// is registered and qualified by fifo_rd_valid for one cycle.
// Optional build macro FIFO_STICKY_ERR_EN: error bits latch until reset_L=0
// instead of pulsing for one cycle.
module fifo_multi_ch #(
    parameter int NUM_CH    = 4,
    parameter int CH_L      = 2,
    parameter int DEPTH     = 8,
    parameter int PTR_L     = 3,
    parameter int WORD_SIZE = 10
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 fifo_wr,
    input  logic [CH_L-1:0]      wr_ch,
    input  logic [WORD_SIZE-1:0] fifo_data_in,
    input  logic                 fifo_rd,
    input  logic [CH_L-1:0]      rd_ch,
    input  logic [PTR_L:0]       full_threshold,
    input  logic [PTR_L:0]       empty_threshold,
    output logic [WORD_SIZE-1:0] fifo_data_out,
    output logic                 fifo_rd_valid,
    output logic [NUM_CH-1:0]    fifo_full,
    output logic [NUM_CH-1:0]    fifo_empty,
    output logic [NUM_CH-1:0]    almost_full,
    output logic [NUM_CH-1:0]    almost_empty,
    output logic [NUM_CH-1:0]    error
);

    localparam logic [PTR_L:0] FULL_CNT = (PTR_L+1)'(DEPTH);

    logic [WORD_SIZE-1:0] mem    [NUM_CH][DEPTH];
    logic [PTR_L-1:0]     wr_ptr [NUM_CH];
    logic [PTR_L-1:0]     rd_ptr [NUM_CH];
    logic [PTR_L:0]       count  [NUM_CH];

    logic                 rd_ok;
    logic                 wr_ok;
    logic [NUM_CH-1:0]    push_sel;
    logic [NUM_CH-1:0]    pop_sel;
    logic [NUM_CH-1:0]    err_vec;

    // Accept/reject decisions for this cycle's push and pop, plus per-channel selects.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        push_sel = '0;
        pop_sel  = '0;
        err_vec  = '0;
        rd_ok    = fifo_rd && (count[rd_ch] != '0);
        // A full channel still takes a push when the same channel pops this cycle.
        wr_ok    = fifo_wr && ((count[wr_ch] != FULL_CNT) || (rd_ok && (rd_ch == wr_ch)));
        for (int i = 0; i < NUM_CH; i++) begin
            push_sel[i] = wr_ok && (wr_ch == CH_L'(i));
            pop_sel[i]  = rd_ok && (rd_ch == CH_L'(i));
        end
        if (fifo_wr && !wr_ok) err_vec[wr_ch] = 1'b1;
        if (fifo_rd && !rd_ok) err_vec[rd_ch] = 1'b1;
    end

    // Storage write; contents are meaningless until the pointers say otherwise.
    // NOTE: the memory array has no reset; pointers and counts alone define validity.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ch][wr_ptr[wr_ch]] <= fifo_data_in;
    end

    // Pointers, counts, registered pop data and error reporting.
    // NOTE: sequential state uses non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            fifo_data_out <= '0;
            fifo_rd_valid <= 1'b0;
            error         <= '0;
        end else begin
            fifo_rd_valid <= rd_ok;
            if (rd_ok) fifo_data_out <= mem[rd_ch][rd_ptr[rd_ch]];
            for (int i = 0; i < NUM_CH; i++) begin
                if (push_sel[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop_sel[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
                case ({push_sel[i], pop_sel[i]})
                    2'b10:   count[i] <= count[i] + 1'b1;
                    2'b01:   count[i] <= count[i] - 1'b1;
                    default: count[i] <= count[i];
                endcase
            end
`ifdef FIFO_STICKY_ERR_EN
            error <= error | err_vec;
`else
            error <= err_vec;
`endif
        end
    end

    // Status flags decoded straight from the registered counts.
    always_comb begin
        fifo_full    = '0;
        fifo_empty   = '0;
        almost_full  = '0;
        almost_empty = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            fifo_full[i]    = (count[i] == FULL_CNT);
            fifo_empty[i]   = (count[i] == '0);
            almost_full[i]  = (count[i] >= full_threshold);
            almost_empty[i] = (count[i] <= empty_threshold);
        end
    end

endmodule

// File: tb/tb_fifo_multi_ch.sv
// Self-checking bench for fifo_multi_ch: table-driven fill/overflow/drain/underflow
// sequence, then hand-written sequences for simultaneous push/pop on a full channel,
// threshold flags and asynchronous reset mid-cycle. Pop data is checked against a
// scoreboard fed from a per-channel queue model.
module tb_fifo_multi_ch;

    localparam int NUM_CH = 4;
    localparam int CH_L   = 2;
    localparam int DEPTH  = 8;
    localparam int PTR_L  = 3;
    localparam int WS     = 10;
`ifdef FIFO_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic              clk;
    logic              reset_L;
    logic              fifo_wr;
    logic [CH_L-1:0]   wr_ch;
    logic [WS-1:0]     fifo_data_in;
    logic              fifo_rd;
    logic [CH_L-1:0]   rd_ch;
    logic [PTR_L:0]    full_threshold;
    logic [PTR_L:0]    empty_threshold;
    logic [WS-1:0]     fifo_data_out;
    logic              fifo_rd_valid;
    logic [NUM_CH-1:0] fifo_full;
    logic [NUM_CH-1:0] fifo_empty;
    logic [NUM_CH-1:0] almost_full;
    logic [NUM_CH-1:0] almost_empty;
    logic [NUM_CH-1:0] error;

    fifo_multi_ch #(
        .NUM_CH(NUM_CH), .CH_L(CH_L), .DEPTH(DEPTH), .PTR_L(PTR_L), .WORD_SIZE(WS)
    ) dut (
        .clk(clk), .reset_L(reset_L),
        .fifo_wr(fifo_wr), .wr_ch(wr_ch), .fifo_data_in(fifo_data_in),
        .fifo_rd(fifo_rd), .rd_ch(rd_ch),
        .full_threshold(full_threshold), .empty_threshold(empty_threshold),
        .fifo_data_out(fifo_data_out), .fifo_rd_valid(fifo_rd_valid),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: per-channel contents, pending pop results, last output word, errors.
    logic [WS-1:0]     mdl [NUM_CH][$];
    logic [WS-1:0]     exp_q [$];
    logic [WS-1:0]     last_out;
    logic [NUM_CH-1:0] err_exp;

    typedef struct {
        logic            wr;
        logic [CH_L-1:0] wch;
        logic [WS-1:0]   din;
        logic            rd;
        logic [CH_L-1:0] rch;
        logic            v;
        logic [3:0]      full;
        logic [3:0]      empty;
        logic [3:0]      err;
    } vec_t;

    vec_t tbl [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int c = 0; c < NUM_CH; c++) mdl[c].delete();
        exp_q.delete();
        last_out = '0;
        err_exp  = '0;
    endtask

    task automatic check_flags(input string tag);
        logic [NUM_CH-1:0] ef, ee, eaf, eae;
        for (int c = 0; c < NUM_CH; c++) begin
            ef[c]  = (mdl[c].size() == DEPTH);
            ee[c]  = (mdl[c].size() == 0);
            eaf[c] = (mdl[c].size() >= int'(full_threshold));
            eae[c] = (mdl[c].size() <= int'(empty_threshold));
        end
        check({tag, " full"},         32'(fifo_full),    32'(ef));
        check({tag, " empty"},        32'(fifo_empty),   32'(ee));
        check({tag, " almost_full"},  32'(almost_full),  32'(eaf));
        check({tag, " almost_empty"}, 32'(almost_empty), 32'(eae));
        check({tag, " error"},        32'(error),        32'(err_exp));
    endtask

    // One clock of stimulus: predict, drive, clock, compare against model and scoreboard.
    task automatic do_cycle(input logic wr, input logic [CH_L-1:0] wch, input logic [WS-1:0] din,
                            input logic rd, input logic [CH_L-1:0] rch);
        logic              rd_acc, wr_acc;
        logic [NUM_CH-1:0] errv;
        errv   = '0;
        rd_acc = rd && (mdl[rch].size() != 0);
        wr_acc = wr && ((mdl[wch].size() < DEPTH) || (rd_acc && (rch == wch)));
        if (rd_acc) exp_q.push_back(mdl[rch].pop_front());
        if (wr_acc) mdl[wch].push_back(din);
        if (wr && !wr_acc) errv[wch] = 1'b1;
        if (rd && !rd_acc) errv[rch] = 1'b1;
        err_exp = STICKY ? (err_exp | errv) : errv;

        fifo_wr = wr; wr_ch = wch; fifo_data_in = din;
        fifo_rd = rd; rd_ch = rch;
        @(posedge clk);
        #1;
        fifo_wr = 1'b0;
        fifo_rd = 1'b0;

        check("rd_valid", 32'(fifo_rd_valid), 32'(rd_acc));
        if (rd_acc) begin
            last_out = exp_q.pop_front();
            check("rd_data", 32'(fifo_data_out), 32'(last_out));
        end else begin
            check("data_hold", 32'(fifo_data_out), 32'(last_out));
        end
        check_flags("cycle");
    endtask

    // Assert reset between clock edges and confirm the clear is immediate.
    task automatic do_reset();
        #3;
        reset_L = 1'b0;
        #1;
        fifo_wr = 1'b0;
        fifo_rd = 1'b0;
        clear_model();
        check("rst data_out", 32'(fifo_data_out), 32'h0);
        check("rst rd_valid", 32'(fifo_rd_valid), 32'h0);
        check_flags("rst");
        #2;
        reset_L = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_L = 1'b0;
        fifo_wr = 1'b0; wr_ch = '0; fifo_data_in = '0;
        fifo_rd = 1'b0; rd_ch = '0;
        full_threshold = 4'd8; empty_threshold = 4'd0;
        clear_model();

        // Table: fill ch1, overflow, drain in order, underflow ch2, idle.
        for (int i = 0; i < 19; i++) begin
            tbl[i].wr = 1'b0; tbl[i].wch = 2'd1; tbl[i].din = '0;
            tbl[i].rd = 1'b0; tbl[i].rch = 2'd1; tbl[i].v = 1'b0;
            tbl[i].full = 4'b0000; tbl[i].empty = 4'b1101; tbl[i].err = 4'b0000;
        end
        for (int i = 0; i < 8; i++) begin
            tbl[i].wr = 1'b1; tbl[i].din = WS'(i + 1);
        end
        tbl[7].full = 4'b0010;
        tbl[8].wr = 1'b1; tbl[8].din = 10'h3FF; tbl[8].full = 4'b0010; tbl[8].err = 4'b0010;
        for (int i = 9; i < 17; i++) begin
            tbl[i].rd = 1'b1; tbl[i].v = 1'b1;
            tbl[i].err = STICKY ? 4'b0010 : 4'b0000;
        end
        tbl[16].empty = 4'b1111;
        tbl[17].rd = 1'b1; tbl[17].rch = 2'd2; tbl[17].empty = 4'b1111;
        tbl[17].err = STICKY ? 4'b0110 : 4'b0100;
        tbl[18].empty = 4'b1111;
        tbl[18].err = STICKY ? 4'b0110 : 4'b0000;

        // Reset state, with reset released between edges.
        #12;
        check("init data_out", 32'(fifo_data_out), 32'h0);
        check("init rd_valid", 32'(fifo_rd_valid), 32'h0);
        check_flags("init");
        #5;
        reset_L = 1'b1;

        for (int i = 0; i < 19; i++) begin
            do_cycle(tbl[i].wr, tbl[i].wch, tbl[i].din, tbl[i].rd, tbl[i].rch);
            check($sformatf("tbl[%0d] valid", i), 32'(fifo_rd_valid), 32'(tbl[i].v));
            check($sformatf("tbl[%0d] full", i),  32'(fifo_full),     32'(tbl[i].full));
            check($sformatf("tbl[%0d] empty", i), 32'(fifo_empty),    32'(tbl[i].empty));
            check($sformatf("tbl[%0d] error", i), 32'(error),         32'(tbl[i].err));
        end
        check("tbl last pop", 32'(fifo_data_out), 32'h008);

        // Full ch0 with simultaneous push and pop; 0x155 must come out last after wrap.
        do_reset();
        for (int i = 0; i < 8; i++) do_cycle(1'b1, 2'd0, WS'(10'h100 + i), 1'b0, 2'd0);
        check("ch0 full", 32'(fifo_full[0]), 32'h1);
        do_cycle(1'b1, 2'd0, 10'h155, 1'b1, 2'd0);
        check("pushpop data", 32'(fifo_data_out), 32'h100);
        check("pushpop still full", 32'(fifo_full[0]), 32'h1);
        check("pushpop no error", 32'(error), 32'h0);
        for (int i = 0; i < 8; i++) do_cycle(1'b0, 2'd0, '0, 1'b1, 2'd0);
        check("wrap last word", 32'(fifo_data_out), 32'h155);
        check("ch0 drained", 32'(fifo_empty[0]), 32'h1);

        // Push to an empty channel with a simultaneous pop: push only, pop underflows.
        do_cycle(1'b1, 2'd1, 10'h2AA, 1'b1, 2'd1);
        check("empty pushpop error", 32'(error[1]), 32'h1);
        do_cycle(1'b0, 2'd1, '0, 1'b1, 2'd1);
        check("empty pushpop data", 32'(fifo_data_out), 32'h2AA);

        // Thresholds on ch3.
        full_threshold = 4'd6; empty_threshold = 4'd2;
        do_reset();
        check("thr rst af", 32'(almost_full), 32'h0);
        check("thr rst ae", 32'(almost_empty), 32'hF);
        for (int i = 0; i < 6; i++) begin
            do_cycle(1'b1, 2'd3, WS'(10'h030 + i), 1'b0, 2'd0);
            check($sformatf("af after %0d", i + 1), 32'(almost_full[3]), 32'(i == 5));
        end
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b0, 2'd0, '0, 1'b1, 2'd3);
            check($sformatf("ae after pop %0d", i + 1), 32'(almost_empty[3]), 32'(i >= 3));
        end

        // ch0 holding 5 words and a push in flight when reset hits mid-cycle.
        full_threshold = 4'd0; empty_threshold = 4'd1;
        do_reset();
        for (int i = 0; i < 6; i++) do_cycle(1'b1, 2'd0, WS'(10'h0A0 + i), 1'b0, 2'd0);
        do_cycle(1'b0, 2'd0, '0, 1'b1, 2'd0);
        check("pre-rst data", 32'(fifo_data_out), 32'h0A0);
        fifo_wr = 1'b1; wr_ch = 2'd0; fifo_data_in = 10'h3C3;
        do_reset();
        check("rst af thr0", 32'(almost_full), 32'hF);
        check("rst ch0 empty", 32'(fifo_empty[0]), 32'h1);
        do_cycle(1'b0, 2'd0, '0, 1'b1, 2'd0);
        check("post-rst underflow", 32'(error[0]), 32'h1);

        check("scoreboard drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo_multi_ch.md
FIFO_MULTI_CH -- requirements
Module: fifo_multi_ch

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent channels.
REQ-002 SHALL have parameter CH_L, default 2, channel index width (log2 NUM_CH).
REQ-003 SHALL have parameter DEPTH, default 8, entries per channel (power of two).
REQ-004 SHALL have parameter PTR_L, default 3, pointer width (log2 DEPTH).
REQ-005 SHALL have parameter WORD_SIZE, default 10, data width.
REQ-006 SHALL have the following ports; one clock; reset is asynchronous and active-low:
  clk  input  1  sole clock, rising edge.
  reset_L  input  1  asynchronous active-low reset.
  fifo_wr  input  1  push request.
  wr_ch  input  CH_L  channel targeted by push.
  fifo_data_in  input  WORD_SIZE  push data.
  fifo_rd  input  1  pop request.
  rd_ch  input  CH_L  channel targeted by pop.
  full_threshold  input  PTR_L+1  almost_full level, shared by all channels.
  empty_threshold  input  PTR_L+1  almost_empty level, shared by all channels.
  fifo_data_out  output  WORD_SIZE  registered pop data.
  fifo_rd_valid  output  1  fifo_data_out updated this cycle.
  fifo_full  output  NUM_CH  per-channel full.
  fifo_empty  output  NUM_CH  per-channel empty.
  almost_full  output  NUM_CH  per-channel count >= full_threshold.
  almost_empty  output  NUM_CH  per-channel count <= empty_threshold.
  error  output  NUM_CH  per-channel overflow/underflow indication.

Function
REQ-007 SHALL keep, per channel, write pointer, read pointer (PTR_L bits, wrap DEPTH-1 -> 0) and count (PTR_L+1 bits, range 0..DEPTH).
REQ-008 SHALL accept a push when fifo_wr=1 and channel wr_ch not full, or full with an accepted pop on the same channel this cycle; store data at that channel's write pointer, advance pointer.
REQ-009 SHALL accept a pop when fifo_rd=1 and channel rd_ch not empty; advance read pointer; fifo_data_out = popped word on next edge, with fifo_rd_valid=1 for that one cycle.
REQ-010 SHALL hold fifo_data_out when no pop accepted; fifo_rd_valid=0.
REQ-011 SHALL update count: +1 push only, -1 pop only, unchanged when both hit the same channel; independent updates when on different channels.
REQ-012 SHALL reject a pop to an empty channel even with a simultaneous push to it (push accepted, count 0 -> 1, pop counted as underflow).
REQ-013 SHALL derive fifo_full (count==DEPTH), fifo_empty (count==0), almost_full, almost_empty combinationally from registered counts.
REQ-014 SHALL treat rejected push (overflow) as data dropped, no pointer/count change, error set on wr_ch.
REQ-015 SHALL treat rejected pop (underflow) as no pointer/count change, fifo_rd_valid=0, error set on rd_ch.
REQ-016 SHALL produce push-to-pop latency of one cycle: word pushed at edge N poppable from edge N+1.

Reset
REQ-017 SHALL on reset_L=0, immediately and independent of clk: clear all pointers and counts, fifo_data_out=0, fifo_rd_valid=0, error=0, memory contents not required cleared.
REQ-018 SHALL after reset show fifo_empty all ones, fifo_full all zeros, almost_empty all ones for any threshold, almost_full=1 only where full_threshold=0.
REQ-019 SHALL discard any push/pop in progress when reset asserts mid-operation.

Configuration
REQ-020 SHALL with FIFO_STICKY_ERR_EN defined hold each error bit at 1 from the first fault until reset_L=0.
REQ-021 SHALL without FIFO_STICKY_ERR_EN drive each error bit as a one-cycle pulse in the cycle after the fault.

Verification
REQ-022 SHALL cover: reset, push 0x001..0x008 to ch1 -> fifo_full[1]=1 after 8th edge, other channels empty.
REQ-023 SHALL cover: 9th push 0x3FF to full ch1 -> dropped, error[1]=1, count stays 8; pops return 0x001..0x008 in order with fifo_rd_valid.
REQ-024 SHALL cover: pop empty ch2 -> fifo_rd_valid=0, error[2]=1 (sticky if FIFO_STICKY_ERR_EN, else one cycle).
REQ-025 SHALL cover: full ch0, same-cycle push 0x155 and pop -> both accepted, count stays 8, 0x155 emerges last after wrap-around.
REQ-026 SHALL cover: full_threshold=6, empty_threshold=2, push ch3 to 6 -> almost_full[3]=1; pop to 2 -> almost_empty[3]=1.
REQ-027 SHALL cover: reset_L pulsed low between edges with ch0 holding 5 words -> flags, counts, outputs cleared immediately.
